// File: rtl/retire_event_counters.sv
// Bank of retire/event counters fed from WB retire lanes, with a registered CSR read port and CSR write port.
// Optional COUNTER_OVF_IRQ_EN adds sticky per-counter overflow flags and an overflow interrupt.
module retire_event_counters #(
  parameter  int NUM_LANES = 2,
  parameter  int NUM_RET   = 13,
  parameter  int CNT_W     = 64,
  localparam int NUM_CNT   = NUM_RET + 3,
  localparam int RT_W      = $clog2(NUM_RET),
  localparam int SEL_W     = $clog2(NUM_CNT)
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [NUM_LANES-1:0]      ret_vld_in,
  input  logic [NUM_LANES*RT_W-1:0] ret_type_in,
  input  logic [NUM_LANES-1:0]      mispre_in,
  input  logic [NUM_LANES-1:0]      e_flag_in,
  input  logic                      ext_irq_in,
  input  logic [NUM_CNT-1:0]        inhibit_in,
  input  logic                      rd_req_in,
  input  logic [SEL_W-1:0]          rd_sel_in,
  output logic                      rd_ack_out,
  output logic [CNT_W-1:0]          rd_data_out,
  input  logic                      wr_en_in,
  input  logic [SEL_W-1:0]          wr_sel_in,
  input  logic [CNT_W-1:0]          wr_data_in,
  output logic [NUM_CNT-1:0]        ovf_flags_out,
  output logic                      ovf_irq_out,
  input  logic [NUM_CNT-1:0]        ovf_clr_in
);

  localparam int INC_W = $clog2(NUM_LANES + 1);

  logic [CNT_W-1:0]   cnt_r [NUM_CNT];
  logic [INC_W-1:0]   inc_s [NUM_CNT];
  logic [CNT_W:0]     sum_s [NUM_CNT];
  logic [NUM_CNT-1:0] wr_hit_s;
  logic [NUM_CNT-1:0] ovf_set_s;
  logic               rd_sel_ok_s;
  logic               rd_ack_r;
  logic [CNT_W-1:0]   rd_data_r;

  // Codes beyond the last RETIRE_TYPE fold into the UNK_RET counter.
  function automatic int unsigned ret_index(input logic [RT_W-1:0] code);
    return (32'(code) >= 32'(NUM_RET)) ? 32'(NUM_RET - 1) : 32'(code);
  endfunction

  // Per-counter increment gathered across all retire lanes
  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      inc_s[k] = '0;
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < NUM_RET; k++) begin
        inc_s[k] = inc_s[k] + INC_W'(ret_vld_in[l] && (ret_index(ret_type_in[l*RT_W +: RT_W]) == k));
      end
      inc_s[NUM_RET]   = inc_s[NUM_RET]   + INC_W'(ret_vld_in[l] & mispre_in[l]);
      inc_s[NUM_RET+2] = inc_s[NUM_RET+2] + INC_W'(ret_vld_in[l] & e_flag_in[l]);
    end
    inc_s[NUM_RET+1] = INC_W'(ext_irq_in);
  end

  // Widened sums expose the carry-out used for wrap detection
  always_comb begin
    rd_sel_ok_s = (32'(rd_sel_in) < 32'(NUM_CNT));
    for (int k = 0; k < NUM_CNT; k++) begin
      sum_s[k]     = {1'b0, cnt_r[k]} + (CNT_W+1)'(inc_s[k]);
      wr_hit_s[k]  = wr_en_in && (wr_sel_in == SEL_W'(k));
      ovf_set_s[k] = !wr_hit_s[k] && !inhibit_in[k] && sum_s[k][CNT_W];
    end
  end

  // Counter bank: a CSR write overrides the increment; inhibit holds the value
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (wr_hit_s[k]) begin
          cnt_r[k] <= wr_data_in;
        end else if (!inhibit_in[k]) begin
          cnt_r[k] <= sum_s[k][CNT_W-1:0];
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  // Read port samples the pre-update value; data holds when idle
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_ack_r  <= 1'b0;
      rd_data_r <= '0;
    end else begin
      rd_ack_r <= rd_req_in;
      if (rd_req_in) begin
        rd_data_r <= rd_sel_ok_s ? cnt_r[rd_sel_in] : '0;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign rd_ack_out  = rd_ack_r;
  assign rd_data_out = rd_data_r;

`ifdef COUNTER_OVF_IRQ_EN
  logic [NUM_CNT-1:0] ovf_flags_r;
  logic [NUM_CNT-1:0] ovf_next_s;
  logic               ovf_irq_r;

  // A set in the same cycle as a clear leaves the flag set.
  assign ovf_next_s = (ovf_flags_r & ~ovf_clr_in) | ovf_set_s;

  // Sticky flags; the irq tracks the next flag state so both rise together
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ovf_flags_r <= '0;
      ovf_irq_r   <= 1'b0;
    end else begin
      ovf_flags_r <= ovf_next_s;
      ovf_irq_r   <= |ovf_next_s;
    end
  end

  assign ovf_flags_out = ovf_flags_r;
  assign ovf_irq_out   = ovf_irq_r;
`else
  logic unused_ovf_s;

  assign unused_ovf_s  = ^{ovf_clr_in, ovf_set_s};
  assign ovf_flags_out = '0;
  assign ovf_irq_out   = 1'b0;
`endif

endmodule
